// File: rtl/host_mem_rd_burst_splitter_if.sv
// Avalon-MM read-only bus bundle. The DUT receives kernel requests on a
// slave port and issues split sub-bursts on a master port.
interface host_mem_rd_burst_splitter_if #(
   parameter int ADDR_W  = 48,
   parameter int DATA_W  = 512,
   parameter int BURST_W = 11
);
   // A request transfers on a rising clk when read=1 and waitrequest=0;
   // the requester holds read/address/burstcount stable while waitrequest=1.
   // Read data has no backpressure: each readdatavalid cycle is one beat.
   logic [ADDR_W-1:0]  address;
   logic [BURST_W-1:0] burstcount;
   logic               read;
   logic               waitrequest;
   logic [DATA_W-1:0]  readdata;
   logic               readdatavalid;

   modport master (
      output address, burstcount, read,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, burstcount, read,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/host_mem_rd_burst_splitter.sv
// Splits arbitrary-length read bursts into sub-bursts of at most MAX_BURST
// beats that never cross a PAGE_BYTES boundary; returns data one cycle later.
module host_mem_rd_burst_splitter #(
   parameter int ADDR_W     = 48,
   parameter int DATA_W     = 512,
   parameter int UP_BURST_W = 11,
   parameter int DN_BURST_W = 6,
   parameter int MAX_BURST  = 32,
   parameter int PAGE_BYTES = 4096
) (
   input  logic                      clk,
   input  logic                      reset_n,
   host_mem_rd_burst_splitter_if.slave  s_bus,
   host_mem_rd_burst_splitter_if.master m_bus,
   output logic [31:0]               split_count,
   output logic                      err_zero_burst,
   output logic                      dbg_state_o
);
   localparam int LINE_BYTES = DATA_W / 8;
   localparam int LINE_LSB   = $clog2(LINE_BYTES);
   localparam int PAGE_LSB   = $clog2(PAGE_BYTES);
   localparam int PAGE_LINES = PAGE_BYTES / LINE_BYTES;

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

   state_e                  state_q;
   logic                    s_wait_q;
   logic                    m_read_q;
   logic [ADDR_W-1:0]       m_addr_q;
   logic [DN_BURST_W-1:0]   m_bc_q;
   logic [UP_BURST_W-1:0]   rem_q;
   logic [31:0]             split_q;
   logic                    err_q;
   logic [DATA_W-1:0]       rdata_q;
   logic                    rvalid_q;

   logic                    s_acc;
   logic                    m_acc;
   logic [ADDR_W-1:0]       addr_first;
   logic [ADDR_W-1:0]       addr_next;
   logic [UP_BURST_W-1:0]   len_first;
   logic [UP_BURST_W-1:0]   len_next;
   logic [UP_BURST_W-1:0]   rem_next;

   // Sub-burst length: min(remaining, MAX_BURST, lines left in this page).
   function automatic logic [UP_BURST_W-1:0] sub_len(
      input logic [ADDR_W-1:0]     addr,
      input logic [UP_BURST_W-1:0] rem
   );
      logic [UP_BURST_W-1:0] page_left;
      logic [UP_BURST_W-1:0] len;
      page_left = UP_BURST_W'(PAGE_LINES) - UP_BURST_W'(addr[PAGE_LSB-1:LINE_LSB]);
      len = rem;
      if (len > UP_BURST_W'(MAX_BURST)) len = UP_BURST_W'(MAX_BURST);
      if (len > page_left) len = page_left;
      return len;
   endfunction

   always_comb begin
      s_acc      = s_bus.read && !s_wait_q;
      m_acc      = m_read_q && !m_bus.waitrequest;
      addr_first = {s_bus.address[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
      len_first  = sub_len(addr_first, s_bus.burstcount);
      addr_next  = m_addr_q + (ADDR_W'(m_bc_q) << LINE_LSB);
      rem_next   = rem_q - UP_BURST_W'(m_bc_q);
      len_next   = sub_len(addr_next, rem_next);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         s_wait_q <= 1'b1;
         m_read_q <= 1'b0;
         m_addr_q <= '0;
         m_bc_q   <= '0;
         rem_q    <= '0;
         split_q  <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         err_q    <= 1'b0;
         rdata_q  <= m_bus.readdata;
         rvalid_q <= m_bus.readdatavalid;
         case (state_q)
            IDLE: begin
               s_wait_q <= 1'b0;
               if (s_acc) begin
                  if (s_bus.burstcount == '0) begin
                     err_q <= 1'b1;
                  end else begin
                     state_q  <= ISSUE;
                     s_wait_q <= 1'b1;
                     m_read_q <= 1'b1;
                     m_addr_q <= addr_first;
                     m_bc_q   <= DN_BURST_W'(len_first);
                     rem_q    <= s_bus.burstcount;
                  end
               end
            end
            ISSUE: begin
               if (m_acc) begin
                  split_q <= split_q + 32'd1;
                  if (rem_q == UP_BURST_W'(m_bc_q)) begin
                     state_q  <= IDLE;
                     m_read_q <= 1'b0;
                     s_wait_q <= 1'b0;
                     rem_q    <= '0;
                  end else begin
                     // Next sub-burst goes out back-to-back with no bubble.
                     m_addr_q <= addr_next;
                     m_bc_q   <= DN_BURST_W'(len_next);
                     rem_q    <= rem_next;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_bus.waitrequest   = s_wait_q;
   assign s_bus.readdata      = rdata_q;
   assign s_bus.readdatavalid = rvalid_q;
   assign m_bus.read          = m_read_q;
   assign m_bus.address       = m_addr_q;
   assign m_bus.burstcount    = m_bc_q;
   assign split_count         = split_q;
   assign err_zero_burst      = err_q;
   assign dbg_state_o         = state_q;
endmodule

// File: tb/tb_host_mem_rd_burst_splitter.sv
// Bench for host_mem_rd_burst_splitter: directed and random bursts against a
// page/max-burst splitting model, plus return-path latency and order checks.
module tb_host_mem_rd_burst_splitter;
   localparam int ADDR_W     = 48;
   localparam int DATA_W     = 512;
   localparam int UP_BURST_W = 11;
   localparam int DN_BURST_W = 6;
   localparam int MAX_BURST  = 32;
   localparam int PAGE_BYTES = 4096;
   localparam int LINE_BYTES = DATA_W / 8;
   localparam int PAGE_LINES = PAGE_BYTES / LINE_BYTES;
   localparam int SUB_W      = ADDR_W + DN_BURST_W;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] split_count;
   logic        err_zero_burst;
   logic        dbg_state;

   int checks   = 0;
   int failures = 0;

   host_mem_rd_burst_splitter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(UP_BURST_W)) s_bus();
   host_mem_rd_burst_splitter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(DN_BURST_W)) m_bus();

   host_mem_rd_burst_splitter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .UP_BURST_W(UP_BURST_W), .DN_BURST_W(DN_BURST_W),
      .MAX_BURST(MAX_BURST), .PAGE_BYTES(PAGE_BYTES)
   ) dut (
      .clk(clk), .reset_n(reset_n), .s_bus(s_bus), .m_bus(m_bus),
      .split_count(split_count), .err_zero_burst(err_zero_burst), .dbg_state_o(dbg_state)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   // Scoreboard storage
   logic [DATA_W-1:0] exp_q[$];
   logic [SUB_W-1:0]  obs_q[$];
   logic [SUB_W-1:0]  exp_sub[$];
   int                exp_split  = 0;
   int                rcv_beats  = 0;
   int                ret_target = 0;
   int                ret_sent   = 0;
   logic              stall_en   = 1'b0;

   task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: walk the burst from the line-aligned start address,
   // cutting at MAX_BURST and at every page boundary.
   task automatic model(input logic [ADDR_W-1:0] addr, input int bc);
      logic [ADDR_W-1:0] a;
      int rem, len, page_left;
      exp_sub.delete();
      a   = addr & ~ADDR_W'(LINE_BYTES - 1);
      rem = bc;
      while (rem > 0) begin
         page_left = PAGE_LINES - int'((a % PAGE_BYTES) / LINE_BYTES);
         len = (rem < MAX_BURST) ? rem : MAX_BURST;
         if (page_left < len) len = page_left;
         exp_sub.push_back({a, DN_BURST_W'(len)});
         a   = a + ADDR_W'(len * LINE_BYTES);
         rem = rem - len;
      end
   endtask

   // Downstream memory driver: random stalls and random return beats.
   initial begin
      logic [DATA_W-1:0] d;
      m_bus.waitrequest   = 1'b0;
      m_bus.readdatavalid = 1'b0;
      m_bus.readdata      = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom();
         m_bus.readdata    = d;
         m_bus.waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
         if (ret_sent < ret_target && $urandom_range(0, 1) == 1) begin
            m_bus.readdatavalid = 1'b1;
            ret_sent++;
         end else begin
            m_bus.readdatavalid = 1'b0;
         end
      end
   end

   // Monitor: downstream request capture/stability and return-path checks.
   logic              last_stall = 1'b0;
   logic [ADDR_W-1:0] last_addr;
   logic [DN_BURST_W-1:0] last_bc;
   logic              prev_v = 1'b0;
   logic [DATA_W-1:0] prev_d;
   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         last_stall = 1'b0;
      end else begin
         if (last_stall) begin
            chk("stall_read", m_bus.read, 1'b1);
            chk("stall_addr", m_bus.address, last_addr);
            chk("stall_bc", m_bus.burstcount, last_bc);
         end
         last_stall = m_bus.read && m_bus.waitrequest;
         last_addr  = m_bus.address;
         last_bc    = m_bus.burstcount;
         if (m_bus.read && !m_bus.waitrequest) obs_q.push_back({m_bus.address, m_bus.burstcount});
         chk("ret_valid", s_bus.readdatavalid, prev_v);
         chk("ret_data", s_bus.readdata, prev_d);
         if (s_bus.readdatavalid) begin
            if (exp_q.size() > 0) chk("ret_order", s_bus.readdata, exp_q.pop_front());
            rcv_beats++;
         end
      end
      prev_v = m_bus.readdatavalid;
      prev_d = m_bus.readdata;
      if (reset_n && m_bus.readdatavalid) exp_q.push_back(m_bus.readdata);
   end

   task automatic send_req(input logic [ADDR_W-1:0] addr, input logic [UP_BURST_W-1:0] bc);
      int cyc;
      s_bus.address    = addr;
      s_bus.burstcount = bc;
      s_bus.read       = 1'b1;
      cyc = 0;
      while (s_bus.waitrequest !== 1'b0 && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("req_accept", s_bus.waitrequest, 1'b0);
      tick();
      s_bus.read = 1'b0;
   endtask

   task automatic run_req(input string name, input logic [ADDR_W-1:0] addr, input int bc, input int budget);
      int cyc;
      model(addr, bc);
      obs_q.delete();
      send_req(addr, UP_BURST_W'(bc));
      cyc = 0;
      while (obs_q.size() < exp_sub.size() && cyc < budget) begin
         tick();
         cyc++;
      end
      chk({name, "_nsub"}, obs_q.size(), exp_sub.size());
      for (int i = 0; i < exp_sub.size(); i++)
         chk($sformatf("%s_sub%0d", name, i), (i < obs_q.size()) ? obs_q[i] : 'x, exp_sub[i]);
      exp_split += exp_sub.size();
      chk({name, "_mread_done"}, m_bus.read, 1'b0);
      chk({name, "_swait_done"}, s_bus.waitrequest, 1'b0);
      chk({name, "_split"}, split_count, exp_split);
   endtask

   initial begin
      int cyc;
      s_bus.read       = 1'b0;
      s_bus.address    = '0;
      s_bus.burstcount = '0;
      reset_n          = 1'b0;
      repeat (2) tick();
      chk("rst_swait", s_bus.waitrequest, 1'b1);
      chk("rst_mread", m_bus.read, 1'b0);
      chk("rst_maddr", m_bus.address, '0);
      chk("rst_mbc", m_bus.burstcount, '0);
      chk("rst_rvalid", s_bus.readdatavalid, 1'b0);
      chk("rst_rdata", s_bus.readdata, '0);
      chk("rst_split", split_count, '0);
      chk("rst_err", err_zero_burst, 1'b0);
      chk("rst_state", dbg_state, 1'b0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      tick();
      chk("rel_swait", s_bus.waitrequest, 1'b0);

      // 64 beats from 0: two back-to-back sub-bursts, cycle exact
      model(48'h0, 64);
      obs_q.delete();
      send_req(48'h0, 11'd64);
      chk("t1_mread0", m_bus.read, 1'b1);
      chk("t1_addr0", m_bus.address, 48'h0);
      chk("t1_bc0", m_bus.burstcount, 6'd32);
      chk("t1_swait", s_bus.waitrequest, 1'b1);
      chk("t1_state", dbg_state, 1'b1);
      tick();
      chk("t1_mread1", m_bus.read, 1'b1);
      chk("t1_addr1", m_bus.address, 48'h800);
      chk("t1_bc1", m_bus.burstcount, 6'd32);
      chk("t1_split1", split_count, 32'd1);
      tick();
      chk("t1_mread_done", m_bus.read, 1'b0);
      chk("t1_swait_done", s_bus.waitrequest, 1'b0);
      chk("t1_split", split_count, 32'd2);
      chk("t1_nsub", obs_q.size(), exp_sub.size());
      exp_split = 2;

      run_req("t2", 48'hFC0, 4, 100);
      run_req("t3", 48'h780, 40, 100);
      run_req("t3b", 48'h123_4567_89AB, 70, 100);

      // Zero-length burst is dropped with a one-cycle error pulse
      obs_q.delete();
      send_req(48'h1234, 11'd0);
      chk("z_err", err_zero_burst, 1'b1);
      chk("z_mread", m_bus.read, 1'b0);
      chk("z_swait", s_bus.waitrequest, 1'b0);
      chk("z_state", dbg_state, 1'b0);
      tick();
      chk("z_err_off", err_zero_burst, 1'b0);
      chk("z_split", split_count, exp_split);
      chk("z_nsub", obs_q.size(), 0);

      // Max burst with random downstream stalls and 1024 returned beats
      stall_en   = 1'b1;
      ret_target = 1024;
      run_req("t4", 48'h0, 1024, 4000);
      cyc = 0;
      while (rcv_beats < 1024 && cyc < 6000) begin
         tick();
         cyc++;
      end
      tick();
      chk("t4_beats", rcv_beats, 1024);
      chk("t4_exp_empty", exp_q.size(), 0);

      // Random bursts, including addresses near the top of the address space
      for (int r = 0; r < 10; r++) begin
         logic [ADDR_W-1:0] a;
         a = {16'($urandom()), 32'($urandom())};
         if (r < 2) a = 48'hFFFF_FFFF_F000 | ADDR_W'($urandom_range(0, 4095));
         run_req($sformatf("rnd%0d", r), a, $urandom_range(1, 300), 2000);
      end

      // Asynchronous reset in the middle of a 4-sub-burst request
      stall_en = 1'b0;
      obs_q.delete();
      send_req(48'h0, 11'd128);
      tick();
      chk("rs_split1", split_count, exp_split + 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rs_mread", m_bus.read, 1'b0);
      chk("rs_swait", s_bus.waitrequest, 1'b1);
      chk("rs_split", split_count, '0);
      chk("rs_state", dbg_state, 1'b0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      tick();
      exp_split = 0;
      chk("rs_swait_rel", s_bus.waitrequest, 1'b0);
      chk("rs_mread_rel", m_bus.read, 1'b0);
      chk("rs_split_rel", split_count, '0);
      run_req("post_rst", 48'h40, 5, 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/host_mem_rd_burst_splitter.md
Name: host_mem_rd_burst_splitter

Overview:
- Avalon-MM read-request splitter that drives the host-memory read path of the host-channel shim.
- Accepts arbitrary-length kernel read bursts and re-issues them as sub-bursts. Each sub-burst is at most MAX_BURST beats and never crosses a PAGE_BYTES boundary, which the VTP translation requires.
- Read responses are returned in order through a one-cycle registered path.
- Read-only block; writes use a separate sibling block.

Parameters:
- ADDR_W, 48, byte-address width on both sides
- DATA_W, 512, data width in bits; one beat = DATA_W/8 bytes (LINE_BYTES)
- UP_BURST_W, 11, upstream burstcount width (max legal burst 1024)
- DN_BURST_W, 6, downstream burstcount width
- MAX_BURST, 32, maximum downstream burst in beats; must be ≤ PAGE_BYTES/LINE_BYTES/2 and < 2^DN_BURST_W
- PAGE_BYTES, 4096, boundary that sub-bursts must not cross

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- s_address  in  ADDR_W  upstream byte address; bits below log2(LINE_BYTES) ignored
- s_burstcount  in  UP_BURST_W  upstream burst length in beats
- s_read  in  1  upstream read request
- s_waitrequest  out  1  upstream stall
- s_readdata  out  DATA_W  returned data
- s_readdatavalid  out  1  returned data valid
- m_address  out  ADDR_W  downstream line-aligned byte address
- m_burstcount  out  DN_BURST_W  downstream burst length
- m_read  out  1  downstream read request
- m_waitrequest  in  1  downstream stall
- m_readdata  in  DATA_W  downstream data
- m_readdatavalid  in  1  downstream data valid
- split_count  out  32  number of downstream sub-bursts issued; wraps at 2^32
- err_zero_burst  out  1  one-cycle pulse when a burstcount-0 request is accepted

Behaviour:
- Reset values: s_waitrequest=1, m_read=0, m_address=0, m_burstcount=0, s_readdatavalid=0, s_readdata=0, split_count=0, err_zero_burst=0. State=IDLE, remaining=0.
- s_waitrequest is asserted during reset and deasserts on the first clk edge after reset_n rises.
- Handshakes:
  - Upstream accept = s_read && !s_waitrequest.
  - Downstream accept = m_read && !m_waitrequest.
  - m_read, m_address and m_burstcount stay stable while m_waitrequest=1.
- All outputs are registered.
- FSM states: IDLE, ISSUE.
- IDLE:
  - s_waitrequest=0, m_read=0.
  - On accept with s_burstcount≠0: latch cur_addr = s_address with line bits zeroed, and remaining = s_burstcount. Go to ISSUE.
  - On accept with s_burstcount=0: drop the request, pulse err_zero_burst next cycle, stay in IDLE.
- ISSUE:
  - s_waitrequest=1, m_read=1, m_address=cur_addr.
  - page_left = PAGE_BYTES/LINE_BYTES − cur_addr[log2(PAGE_BYTES)-1 : log2(LINE_BYTES)].
  - m_burstcount = min(remaining, MAX_BURST, page_left).
  - The next value is computed combinationally and registered, so m_read rises on the cycle after upstream accept (1-cycle request latency).
  - On downstream accept: cur_addr += m_burstcount*LINE_BYTES; remaining −= m_burstcount; split_count += 1.
  - If remaining == m_burstcount, go to IDLE (m_read=0 next cycle); otherwise present the next sub-burst on the next cycle with no bubble.
- Consecutive upstream requests have one IDLE cycle between them (s_waitrequest low for one cycle).
- Read return path: s_readdata and s_readdatavalid are registered copies of m_readdata and m_readdatavalid (latency 1, no backpressure, order preserved). Return-path data is independent of the FSM state.
- Address arithmetic wraps modulo 2^ADDR_W. No sub-burst ever spans two pages.
- Reset mid-operation: the FSM returns to IDLE and the unissued remainder is discarded. The in-flight return pipeline register is cleared. The upstream master is required to be reset together with this block.

Test Plan:
- s_address=0x0, s_burstcount=64, m_waitrequest=0 -> two sub-bursts (0x000,32) and (0x800,32) on consecutive cycles; split_count=2; s_waitrequest low again one cycle later.
- s_address=0xFC0, s_burstcount=4 -> (0xFC0,1) then (0x1000,3).
- s_address=0x780, s_burstcount=40 -> (0x780,32), (0xF80,2), (0x1000,6).
- s_address=0x0, s_burstcount=1024, m_waitrequest toggling randomly -> 32 sub-bursts of 32 at 0x800 strides; request fields stable while stalled; split_count=32; 1024 readdatavalid beats returned in order, each 1 cycle after m_readdatavalid.
- s_burstcount=0 accepted -> no m_read; err_zero_burst high exactly 1 cycle; split_count unchanged.
- reset_n pulled low in ISSUE after first of 4 sub-bursts -> m_read=0 and s_waitrequest=1 immediately (asynchronous); after release, IDLE and split_count=0.
